// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared types, default raster timing and config validation
package video_timing_pkg;
  localparam int CW = 12;
  localparam int DEF_H_ACT = 640;
  localparam int DEF_H_FP_END = 664;
  localparam int DEF_H_SY_END = 720;
  localparam int DEF_H_TOT = 800;
  localparam int DEF_V_ACT = 480;
  localparam int DEF_V_FP_END = 483;
  localparam int DEF_V_SY_END = 487;
  localparam int DEF_V_TOT = 500;
  typedef enum logic {IDLE, RUN} vtg_state_e;
  typedef struct packed {
    logic [CW-1:0] tot;
    logic [CW-1:0] sy_end;
    logic [CW-1:0] fp_end;
    logic [CW-1:0] act;
  } axis_cfg_t;
  typedef struct packed {
    axis_cfg_t h;
    axis_cfg_t v;
    logic hpol;
    logic vpol;
  } vtg_cfg_t;
  function automatic logic axis_valid(axis_cfg_t a);
    return a.act != '0 && a.act <= a.fp_end && a.fp_end < a.sy_end && a.sy_end < a.tot;
  endfunction
endpackage

// File: rtl/video_timing_if.sv
// video_timing_if: config strobe bus and raster outputs (line irq under VIDEO_TIMING_LINE_IRQ_EN)
interface video_timing_if;
  import video_timing_pkg::*;
  logic enable, cfg_wr, cfg_hpol, cfg_vpol, cfg_pending, cfg_err;
  logic [4*CW-1:0] cfg_h, cfg_v;
  logic hsync, vsync, hblank, vblank, de, sol, sof;
  logic [CW-1:0] x, y;
`ifdef VIDEO_TIMING_LINE_IRQ_EN
  logic [CW-1:0] line_cmp;
  logic line_irq;
`endif
  modport master (
`ifdef VIDEO_TIMING_LINE_IRQ_EN
    output line_cmp, input line_irq,
`endif
    output enable, cfg_wr, cfg_h, cfg_v, cfg_hpol, cfg_vpol,
    input cfg_pending, cfg_err, hsync, vsync, hblank, vblank, de, x, y, sol, sof
  );
  modport slave (
`ifdef VIDEO_TIMING_LINE_IRQ_EN
    input line_cmp, output line_irq,
`endif
    input enable, cfg_wr, cfg_h, cfg_v, cfg_hpol, cfg_vpol,
    output cfg_pending, cfg_err, hsync, vsync, hblank, vblank, de, x, y, sol, sof
  );
endinterface

// File: rtl/video_axis_counter.sv
// video_axis_counter: one raster axis counter with decode of its next value
module video_axis_counter import video_timing_pkg::*; (
  input  logic aclk,
  input  logic areset,
  input  logic run,
  input  logic adv,
  input  logic [CW-1:0] tot,
  input  logic [CW-1:0] act,
  input  logic [CW-1:0] fp_end,
  input  logic [CW-1:0] sy_end,
  output logic [CW-1:0] cnt,
  output logic [CW-1:0] cnt_nxt,
  output logic blank,
  output logic sync_raw,
  output logic wrap
);
  assign wrap = adv && cnt >= tot - CW'(1);
  assign cnt_nxt = !run || wrap ? '0 : adv ? cnt + CW'(1) : cnt;
  assign blank = !run || cnt_nxt >= act;
  assign sync_raw = run && cnt_nxt >= fp_end && cnt_nxt < sy_end;
  // count register; decode above is of the value it is about to take
  always_ff @(posedge aclk) cnt <= areset ? '0 : cnt_nxt;
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: programmable raster timing generator, optional line irq via VIDEO_TIMING_LINE_IRQ_EN
module video_timing_gen import video_timing_pkg::*; #(
  parameter int H_ACT = DEF_H_ACT,
  parameter int H_FP_END = DEF_H_FP_END,
  parameter int H_SY_END = DEF_H_SY_END,
  parameter int H_TOT = DEF_H_TOT,
  parameter int V_ACT = DEF_V_ACT,
  parameter int V_FP_END = DEF_V_FP_END,
  parameter int V_SY_END = DEF_V_SY_END,
  parameter int V_TOT = DEF_V_TOT
) (
  input logic aclk,
  input logic areset,
  video_timing_if.slave vt
);
  localparam vtg_cfg_t DEF_CFG = {CW'(H_TOT), CW'(H_SY_END), CW'(H_FP_END), CW'(H_ACT),
                                  CW'(V_TOT), CW'(V_SY_END), CW'(V_FP_END), CW'(V_ACT), 2'b00};
  vtg_state_e state;
  vtg_cfg_t act, pend, wr_set, act_n;
  logic pend_f, run, wr_ok, h_adv, h_wrap, v_wrap, h_blank, v_blank, h_sync, v_sync;
  logic [CW-1:0] h_nxt, v_nxt;
  assign run = state == RUN;
  assign h_adv = run && vt.enable;
  assign wr_set = {vt.cfg_h, vt.cfg_v, vt.cfg_hpol, vt.cfg_vpol};
  assign wr_ok = vt.cfg_wr && axis_valid(wr_set.h) && axis_valid(wr_set.v);
  assign act_n = wr_ok && (!run || v_wrap) ? wr_set : v_wrap && pend_f ? pend : act;
  assign vt.cfg_pending = pend_f;
  video_axis_counter u_h (
    .aclk(aclk), .areset(areset), .run(vt.enable), .adv(h_adv),
    .tot(act.h.tot), .act(act_n.h.act), .fp_end(act_n.h.fp_end), .sy_end(act_n.h.sy_end),
    .cnt(vt.x), .cnt_nxt(h_nxt), .blank(h_blank), .sync_raw(h_sync), .wrap(h_wrap)
  );
  video_axis_counter u_v (
    .aclk(aclk), .areset(areset), .run(vt.enable), .adv(h_wrap),
    .tot(act.v.tot), .act(act_n.v.act), .fp_end(act_n.v.fp_end), .sy_end(act_n.v.sy_end),
    .cnt(vt.y), .cnt_nxt(v_nxt), .blank(v_blank), .sync_raw(v_sync), .wrap(v_wrap)
  );
  // run/idle FSM, config shadowing and registered raster outputs
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
      act <= DEF_CFG;
      pend <= DEF_CFG;
      pend_f <= 1'b0;
      vt.cfg_err <= 1'b0;
      vt.hsync <= 1'b1;
      vt.vsync <= 1'b1;
      vt.hblank <= 1'b1;
      vt.vblank <= 1'b1;
      vt.de <= 1'b0;
      vt.sol <= 1'b0;
      vt.sof <= 1'b0;
`ifdef VIDEO_TIMING_LINE_IRQ_EN
      vt.line_irq <= 1'b0;
`endif
    end else begin
      state <= vt.enable ? RUN : IDLE;
      act <= act_n;
      if (wr_ok) pend <= wr_set;
      pend_f <= run ? !v_wrap && (pend_f || wr_ok) : pend_f && !wr_ok;
      vt.cfg_err <= vt.cfg_wr && !wr_ok;
      vt.hsync <= h_sync ~^ act_n.hpol;
      vt.vsync <= v_sync ~^ act_n.vpol;
      vt.hblank <= h_blank;
      vt.vblank <= v_blank;
      vt.de <= !h_blank && !v_blank;
      vt.sol <= vt.enable && h_nxt == '0;
      vt.sof <= vt.enable && h_nxt == '0 && v_nxt == '0;
`ifdef VIDEO_TIMING_LINE_IRQ_EN
      vt.line_irq <= vt.enable && h_nxt == '0 && v_nxt == vt.line_cmp;
`endif
    end
  end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed checks of the raster generator
module tb_video_timing_gen;
  import video_timing_pkg::*;
  localparam axis_cfg_t DH = {12'd800, 12'd720, 12'd664, 12'd640};
  localparam axis_cfg_t DV = {12'd500, 12'd487, 12'd483, 12'd480};
  localparam axis_cfg_t HA = {12'd40, 12'd36, 12'd34, 12'd32};
  localparam axis_cfg_t VA = {12'd12, 12'd11, 12'd10, 12'd8};
  localparam axis_cfg_t HB = {12'd100, 12'd90, 12'd80, 12'd64};
  localparam axis_cfg_t VB = {12'd20, 12'd18, 12'd16, 12'd10};
  localparam axis_cfg_t HC = {12'd60, 12'd56, 12'd52, 12'd48};
  localparam axis_cfg_t VC = {12'd10, 12'd9, 12'd8, 12'd6};
  localparam logic [7:0] IDLE_FLAGS = 8'b1111_0000;
  logic aclk = 1'b0;
  logic areset = 1'b1;
  int checks = 0;
  int errors = 0;
  video_timing_if vif();
  video_timing_gen dut (.aclk(aclk), .areset(areset), .vt(vif));
  always #5 aclk = ~aclk;
  logic [2*CW+7:0] obs;
  assign obs = {vif.x, vif.y, vif.hsync, vif.vsync, vif.hblank, vif.vblank, vif.de, vif.sol, vif.sof, vif.cfg_pending};

  // expected {hsync, vsync, hblank, vblank, de, sol, sof, cfg_pending} at a raster position
  function automatic logic [7:0] model(int x, int y, axis_cfg_t h, axis_cfg_t v, logic hp, logic vp, logic pend);
    logic hb, vb, hs, vs;
    hb = x >= int'(h.act);
    vb = y >= int'(v.act);
    hs = x >= int'(h.fp_end) && x < int'(h.sy_end);
    vs = y >= int'(v.fp_end) && y < int'(v.sy_end);
    return {hp ? hs : !hs, vp ? vs : !vs, hb, vb, !hb && !vb, x == 0, x == 0 && y == 0, pend};
  endfunction

  task automatic cycles_to_sof(output int n);
    n = 0;
    do begin @(negedge aclk); n++; end while (vif.sof !== 1'b1 && n < 5000);
  endtask

  task automatic cycles_to_xy(input int tx, input int ty, output int n);
    n = 0;
    do begin @(negedge aclk); n++; end while ((vif.x !== CW'(tx) || vif.y !== CW'(ty)) && n < 5000);
  endtask

  task automatic write_cfg(input axis_cfg_t h, input axis_cfg_t v, input logic hp, input logic vp);
    vif.cfg_h = h;
    vif.cfg_v = v;
    vif.cfg_hpol = hp;
    vif.cfg_vpol = vp;
    vif.cfg_wr = 1'b1;
    @(negedge aclk);
    vif.cfg_wr = 1'b0;
  endtask

  task automatic test_reset;
    areset = 1'b1;
    repeat (3) @(negedge aclk);
    checks++;
    if ({obs, vif.cfg_err} !== {24'd0, IDLE_FLAGS, 1'b0}) begin errors++; $display("FAIL reset got %h expected %h", {obs, vif.cfg_err}, {24'd0, IDLE_FLAGS, 1'b0}); end
    areset = 1'b0;
    @(negedge aclk);
    checks++;
    if (obs !== {24'd0, IDLE_FLAGS}) begin errors++; $display("FAIL idle_after_reset got %h expected %h", obs, {24'd0, IDLE_FLAGS}); end
  endtask

  task automatic test_defaults;
    vif.enable = 1'b1;
    for (int c = 0; c < 800; c++) begin
      @(negedge aclk);
      checks++;
      if (obs !== {CW'(c), CW'(0), model(c, 0, DH, DV, 0, 0, 0)}) begin errors++; $display("FAIL default_line x=%0d got %h expected %h", c, obs, {CW'(c), CW'(0), model(c, 0, DH, DV, 0, 0, 0)}); end
    end
    @(negedge aclk);
    checks++;
    if (obs !== {CW'(0), CW'(1), model(0, 1, DH, DV, 0, 0, 0)}) begin errors++; $display("FAIL default_line2 got %h expected %h", obs, {CW'(0), CW'(1), model(0, 1, DH, DV, 0, 0, 0)}); end
    vif.enable = 1'b0;
    @(negedge aclk);
    checks++;
    if (obs !== {24'd0, IDLE_FLAGS}) begin errors++; $display("FAIL default_stop got %h expected %h", obs, {24'd0, IDLE_FLAGS}); end
  endtask

  task automatic test_idle_write;
    write_cfg(HA, VA, 0, 0);
    checks++;
    if ({obs, vif.cfg_err} !== {24'd0, IDLE_FLAGS, 1'b0}) begin errors++; $display("FAIL idle_write got %h expected %h", {obs, vif.cfg_err}, {24'd0, IDLE_FLAGS, 1'b0}); end
    vif.enable = 1'b1;
    for (int i = 0; i <= 480; i++) begin
      @(negedge aclk);
      checks++;
      if (obs !== {CW'(i % 40), CW'((i / 40) % 12), model(i % 40, (i / 40) % 12, HA, VA, 0, 0, 0)}) begin errors++; $display("FAIL frame_a i=%0d got %h expected %h", i, obs, {CW'(i % 40), CW'((i / 40) % 12), model(i % 40, (i / 40) % 12, HA, VA, 0, 0, 0)}); end
    end
  endtask

  task automatic test_pending;
    int n;
    repeat (5) @(negedge aclk);
    write_cfg(HB, VB, 1, 1);
    checks++;
    if ({vif.cfg_pending, vif.x} !== {1'b1, CW'(6)}) begin errors++; $display("FAIL pend_set got %h expected %h", {vif.cfg_pending, vif.x}, {1'b1, CW'(6)}); end
    cycles_to_xy(39, 11, n);
    checks++;
    if ({n, vif.cfg_pending} !== {32'd473, 1'b1}) begin errors++; $display("FAIL pend_hold got %h expected %h", {n, vif.cfg_pending}, {32'd473, 1'b1}); end
    for (int i = 0; i <= 2000; i++) begin
      @(negedge aclk);
      checks++;
      if (obs !== {CW'(i % 100), CW'((i / 100) % 20), model(i % 100, (i / 100) % 20, HB, VB, 1, 1, 0)}) begin errors++; $display("FAIL frame_b i=%0d got %h expected %h", i, obs, {CW'(i % 100), CW'((i / 100) % 20), model(i % 100, (i / 100) % 20, HB, VB, 1, 1, 0)}); end
    end
  endtask

  task automatic test_cfg_err;
    int n;
    repeat (3) @(negedge aclk);
    write_cfg({12'd100, 12'd90, 12'd80, 12'd0}, VB, 0, 0);
    checks++;
    if ({vif.cfg_err, vif.cfg_pending} !== 2'b10) begin errors++; $display("FAIL err_act0 got %b expected 10", {vif.cfg_err, vif.cfg_pending}); end
    @(negedge aclk);
    checks++;
    if ({vif.cfg_err, vif.cfg_pending} !== 2'b00) begin errors++; $display("FAIL err_act0_pulse got %b expected 00", {vif.cfg_err, vif.cfg_pending}); end
    write_cfg(HB, {12'd20, 12'd16, 12'd16, 12'd10}, 0, 0);
    checks++;
    if ({vif.cfg_err, vif.cfg_pending} !== 2'b10) begin errors++; $display("FAIL err_sync got %b expected 10", {vif.cfg_err, vif.cfg_pending}); end
    @(negedge aclk);
    checks++;
    if ({vif.cfg_err, vif.cfg_pending} !== 2'b00) begin errors++; $display("FAIL err_sync_pulse got %b expected 00", {vif.cfg_err, vif.cfg_pending}); end
    cycles_to_sof(n);
    checks++;
    if (n !== 1993) begin errors++; $display("FAIL err_wrap got %0d expected 1993", n); end
    checks++;
    if (obs !== {24'd0, model(0, 0, HB, VB, 1, 1, 0)}) begin errors++; $display("FAIL err_keep got %h expected %h", obs, {24'd0, model(0, 0, HB, VB, 1, 1, 0)}); end
    cycles_to_sof(n);
    checks++;
    if (n !== 2000) begin errors++; $display("FAIL err_period got %0d expected 2000", n); end
  endtask

  task automatic test_back_to_back;
    int n;
    repeat (2) @(negedge aclk);
    vif.cfg_h = HA;
    vif.cfg_v = VA;
    vif.cfg_hpol = 1'b0;
    vif.cfg_vpol = 1'b0;
    vif.cfg_wr = 1'b1;
    @(negedge aclk);
    vif.cfg_h = HC;
    vif.cfg_v = VC;
    @(negedge aclk);
    vif.cfg_wr = 1'b0;
    checks++;
    if (vif.cfg_pending !== 1'b1) begin errors++; $display("FAIL b2b_pend got %b expected 1", vif.cfg_pending); end
    cycles_to_sof(n);
    checks++;
    if ({n, obs} !== {32'd1996, 24'd0, model(0, 0, HC, VC, 0, 0, 0)}) begin errors++; $display("FAIL b2b_wrap got %h expected %h", {n, obs}, {32'd1996, 24'd0, model(0, 0, HC, VC, 0, 0, 0)}); end
    cycles_to_sof(n);
    checks++;
    if (n !== 600) begin errors++; $display("FAIL b2b_period got %0d expected 600", n); end
    cycles_to_xy(59, 9, n);
    checks++;
    if (n !== 599) begin errors++; $display("FAIL wrap_pos got %0d expected 599", n); end
    write_cfg(HA, VA, 0, 0);
    checks++;
    if (obs !== {24'd0, model(0, 0, HA, VA, 0, 0, 0)}) begin errors++; $display("FAIL wrap_write got %h expected %h", obs, {24'd0, model(0, 0, HA, VA, 0, 0, 0)}); end
    cycles_to_sof(n);
    checks++;
    if (n !== 480) begin errors++; $display("FAIL wrap_period got %0d expected 480", n); end
  endtask

  task automatic test_stop;
    int n;
    cycles_to_xy(20, 5, n);
    checks++;
    if (n !== 220) begin errors++; $display("FAIL stop_pos got %0d expected 220", n); end
    vif.enable = 1'b0;
    repeat (2) begin
      @(negedge aclk);
      checks++;
      if ({obs, vif.cfg_err} !== {24'd0, IDLE_FLAGS, 1'b0}) begin errors++; $display("FAIL stop_idle got %h expected %h", {obs, vif.cfg_err}, {24'd0, IDLE_FLAGS, 1'b0}); end
    end
    vif.enable = 1'b1;
    @(negedge aclk);
    checks++;
    if (obs !== {24'd0, model(0, 0, HA, VA, 0, 0, 0)}) begin errors++; $display("FAIL restart got %h expected %h", obs, {24'd0, model(0, 0, HA, VA, 0, 0, 0)}); end
    cycles_to_sof(n);
    checks++;
    if (n !== 480) begin errors++; $display("FAIL restart_period got %0d expected 480", n); end
  endtask

`ifdef VIDEO_TIMING_LINE_IRQ_EN
  task automatic test_line_irq;
    int cnt;
    logic [2*CW-1:0] pos;
    vif.line_cmp = 12'd5;
    cnt = 0;
    pos = '1;
    for (int i = 0; i < 480; i++) begin
      @(negedge aclk);
      if (vif.line_irq === 1'b1) begin cnt++; pos = {vif.x, vif.y}; end
    end
    checks++;
    if ({cnt, pos} !== {32'd1, CW'(0), CW'(5)}) begin errors++; $display("FAIL line_irq got %h expected %h", {cnt, pos}, {32'd1, CW'(0), CW'(5)}); end
    vif.line_cmp = 12'd600;
    cnt = 0;
    for (int i = 0; i < 480; i++) begin
      @(negedge aclk);
      if (vif.line_irq === 1'b1) cnt++;
    end
    checks++;
    if (cnt !== 0) begin errors++; $display("FAIL line_irq_out_of_range got %0d expected 0", cnt); end
  endtask
`endif

  task automatic test_areset;
    int n;
    cycles_to_xy(20, 5, n);
    checks++;
    if (n !== 220) begin errors++; $display("FAIL rst_pos got %0d expected 220", n); end
    write_cfg(HB, VB, 1, 1);
    checks++;
    if (vif.cfg_pending !== 1'b1) begin errors++; $display("FAIL rst_pend got %b expected 1", vif.cfg_pending); end
    areset = 1'b1;
    @(negedge aclk);
    checks++;
    if ({obs, vif.cfg_err} !== {24'd0, IDLE_FLAGS, 1'b0}) begin errors++; $display("FAIL rst_mid got %h expected %h", {obs, vif.cfg_err}, {24'd0, IDLE_FLAGS, 1'b0}); end
    areset = 1'b0;
    @(negedge aclk);
    checks++;
    if (obs !== {24'd0, model(0, 0, DH, DV, 0, 0, 0)}) begin errors++; $display("FAIL rst_restart got %h expected %h", obs, {24'd0, model(0, 0, DH, DV, 0, 0, 0)}); end
    cycles_to_xy(640, 0, n);
    checks++;
    if ({n, obs} !== {32'd640, CW'(640), CW'(0), model(640, 0, DH, DV, 0, 0, 0)}) begin errors++; $display("FAIL rst_defaults got %h expected %h", {n, obs}, {32'd640, CW'(640), CW'(0), model(640, 0, DH, DV, 0, 0, 0)}); end
    cycles_to_xy(664, 0, n);
    checks++;
    if ({n, vif.hsync} !== {32'd24, 1'b0}) begin errors++; $display("FAIL rst_hsync got %h expected %h", {n, vif.hsync}, {32'd24, 1'b0}); end
  endtask

  initial begin
    vif.enable = 1'b0;
    vif.cfg_wr = 1'b0;
    vif.cfg_h = DH;
    vif.cfg_v = DV;
    vif.cfg_hpol = 1'b0;
    vif.cfg_vpol = 1'b0;
`ifdef VIDEO_TIMING_LINE_IRQ_EN
    vif.line_cmp = '0;
`endif
    test_reset;
    test_defaults;
    test_idle_write;
    test_pending;
    test_cfg_err;
    test_back_to_back;
    test_stop;
`ifdef VIDEO_TIMING_LINE_IRQ_EN
    test_line_irq;
`endif
    test_areset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
